// File: rtl/pipelined_rca_32bit_pkg.sv
// Shared constants and stage bundles for the 32-bit pipelined
// ripple-carry adder: widths, slice count and pipeline latency.
package pipelined_rca_32bit_pkg;

    localparam int N          = 32;
    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = N / SLICE_W;
    localparam int STAGES     = 3;

    // Stage 1: slice-0 result plus unprocessed upper operands.
    typedef struct packed {
        logic [7:0]  sum;
        logic        c;
        logic [23:0] a;
        logic [23:0] b;
    } st1_t;

    // Stage 2: slices 0-1 done.
    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic [15:0] a;
        logic [15:0] b;
    } st2_t;

    // Stage 3: slices 0-2 done; top byte left for slice 3.
    typedef struct packed {
        logic [23:0] sum;
        logic        c;
        logic [7:0]  a;
        logic [7:0]  b;
    } st3_t;

endpackage

// File: rtl/pipelined_rca_32bit_if.sv
// Operand/result bundle of the pipelined adder.
// master drives A, B, cin; slave returns sum, cout.
interface pipelined_rca_32bit_if;
    import pipelined_rca_32bit_pkg::*;

    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;

    modport master (
        output A,
        output B,
        output cin,
        input  sum,
        input  cout
    );

    modport slave (
        input  A,
        input  B,
        input  cin,
        output sum,
        output cout
    );

endinterface

// File: rtl/pipelined_rca_32bit_rca_slice.sv
// SLICE_W-bit ripple adder built from full-adder cells.
// Ports: a, b (operands), ci (carry in) -> s (sum), co (carry out).
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_slice
    import pipelined_rca_32bit_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);
    logic [SLICE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        fa_cell u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[SLICE_W];
endmodule

// File: rtl/pipelined_rca_32bit.sv
// 32-bit adder as four 8-bit ripple slices with a register after
// each of the first three; result 3 edges after operand capture.
// Ports: clk, rst (sync, active-high), bus (slave: A,B,cin -> sum,cout).
module pipelined_rca_32bit
    import pipelined_rca_32bit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    pipelined_rca_32bit_if.slave bus
);
    st1_t st1_d, st1_q;
    st2_t st2_d, st2_q;
    st3_t st3_d, st3_q;

    logic [7:0] s0_s, s1_s, s2_s, s3_s;
    logic       s0_c, s1_c, s2_c, s3_c;

    rca_slice u_s0 (
        .a  (bus.A[7:0]),
        .b  (bus.B[7:0]),
        .ci (bus.cin),
        .s  (s0_s),
        .co (s0_c)
    );

    rca_slice u_s1 (
        .a  (st1_q.a[7:0]),
        .b  (st1_q.b[7:0]),
        .ci (st1_q.c),
        .s  (s1_s),
        .co (s1_c)
    );

    rca_slice u_s2 (
        .a  (st2_q.a[7:0]),
        .b  (st2_q.b[7:0]),
        .ci (st2_q.c),
        .s  (s2_s),
        .co (s2_c)
    );

    // Last slice is unregistered and drives the top byte and cout.
    rca_slice u_s3 (
        .a  (st3_q.a),
        .b  (st3_q.b),
        .ci (st3_q.c),
        .s  (s3_s),
        .co (s3_c)
    );

    always_comb begin
        st1_d     = '0;
        st1_d.sum = s0_s;
        st1_d.c   = s0_c;
        st1_d.a   = bus.A[31:8];
        st1_d.b   = bus.B[31:8];

        st2_d     = '0;
        st2_d.sum = {s1_s, st1_q.sum};
        st2_d.c   = s1_c;
        st2_d.a   = st1_q.a[23:8];
        st2_d.b   = st1_q.b[23:8];

        st3_d     = '0;
        st3_d.sum = {s2_s, st2_q.sum};
        st3_d.c   = s2_c;
        st3_d.a   = st2_q.a[15:8];
        st3_d.b   = st2_q.b[15:8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st1_q <= '0;
            st2_q <= '0;
            st3_q <= '0;
        end else begin
            st1_q <= st1_d;
            st2_q <= st2_d;
            st3_q <= st3_d;
        end
    end

    assign bus.sum  = {s3_s, st3_q.sum};
    assign bus.cout = s3_c;

endmodule

// File: tb/tb_pipelined_rca_32bit.sv
// Bench for pipelined_rca_32bit: directed vectors, reset cases and
// random back-to-back traffic checked against a delayed-sum model.
module tb_pipelined_rca_32bit;
    import pipelined_rca_32bit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_rca_32bit_if bus ();

    pipelined_rca_32bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Expected {cout,sum} for the last STAGES captured edges.
    logic [32:0] pipe [STAGES];

    task automatic check(input string tag, input logic [32:0] exp);
        logic [32:0] got;
        got = {bus.cout, bus.sum};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a,
                        input logic [31:0] b, input logic c,
                        input string tag);
        @(negedge clk);
        rst     = r;
        bus.A   = a;
        bus.B   = b;
        bus.cin = c;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < STAGES; i++) pipe[i] = '0;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = {1'b0, a} + {1'b0, b} + 33'(c);
        end
        #1 check(tag, pipe[STAGES-1]);
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic [32:0] exp,
                            input string tag);
        repeat (STAGES) step(1'b0, a, b, c, "fill");
        check(tag, exp);
        step(1'b0, a, b, c, "hold");
        check({tag, "_held"}, exp);
    endtask

    logic [31:0] ra, rb;
    logic        rc;
    logic [31:0] pa, pb;
    logic        pc;

    initial begin
        rst     = 1'b1;
        bus.A   = '0;
        bus.B   = '0;
        bus.cin = 1'b0;
        for (int i = 0; i < STAGES; i++) pipe[i] = '0;

        step(1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, "rst0");
        step(1'b1, 32'hCAFEF00D, 32'h0F0F0F0F, 1'b1, "rst1");
        check("reset_zero", 33'h0);

        directed(32'hFFFFFFFF, 32'h0, 1'b0, {1'b0, 32'hFFFFFFFF}, "ff_p_0");
        directed(32'h1, 32'h1, 1'b1, {1'b0, 32'h3}, "1_1_1");
        directed(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0,
                 {1'b0, 32'hFFFFFFFE}, "7f_7f");
        directed(32'h80000000, 32'h80000000, 1'b0,
                 {1'b1, 32'h0}, "80_80");
        directed(32'h12345678, 32'h87654321, 1'b1,
                 {1'b0, 32'h9999999A}, "mixed");
        directed(32'hAAAAAAAA, 32'h55555555, 1'b1,
                 {1'b1, 32'h0}, "ripple_all");
        directed(32'hFFFFFFFF, 32'h1, 1'b0, {1'b1, 32'h0}, "wrap");

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            step(1'b0, ra, rb, rc, "rand");
        end

        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            step(1'b0, ra, rb, 1'b1, "inflight");
        end
        step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "mid_rst");
        check("mid_rst_zero", 33'h0);

        pa = $urandom;
        pb = $urandom;
        pc = 1'b1;
        step(1'b0, pa, pb, pc, "post_rst0");
        check("post_rst_empty0", 33'h0);
        step(1'b0, $urandom, $urandom, 1'b0, "post_rst1");
        check("post_rst_empty1", 33'h0);
        step(1'b0, $urandom, $urandom, 1'b0, "post_rst2");
        check("post_rst_first", {1'b0, pa} + {1'b0, pb} + 33'(pc));

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            step(1'b0, ra, rb, rc, "rand_tail");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
